// File: rtl/memwb_pkg.sv
// memwb_pkg: shared types and default widths for the MEM/WB stage
package memwb_pkg;
  localparam int XLEN_DEF = 64;
  localparam int RADDR_W_DEF = 5;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} memwb_state_e;
  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic [XLEN_DEF-1:0] read_data;
    logic [RADDR_W_DEF-1:0] rd;
    logic memtoreg;
    logic regwrite;
  } memwb_entry_t;
endpackage

// File: rtl/memwb_slot.sv
// memwb_slot: one entry register with load enable and synchronous active-low reset
import memwb_pkg::*;
module memwb_slot #(
  parameter type entry_t = memwb_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  entry_t d,
  output entry_t q
);
  always_ff @(posedge clk)
    if (!reset) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/memwb_stage.sv
// memwb_stage: MEM/WB skid-buffered pipeline stage; MEMWB_FWD_EN adds the fwd_* forwarding port
import memwb_pkg::*;
module memwb_stage #(
  parameter int XLEN = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    result_in,
  input  logic [XLEN-1:0]    read_data_in,
  input  logic [RADDR_W-1:0] rd_in,
  input  logic               memtoreg_in,
  input  logic               regwrite_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result_out,
  output logic [XLEN-1:0]    read_data_out,
  output logic [RADDR_W-1:0] rd_out,
  output logic               memtoreg_out,
  output logic               regwrite_out,
  output logic [XLEN-1:0]    wb_data
`ifdef MEMWB_FWD_EN
  ,
  output logic               fwd_en,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data
`endif
);
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] read_data;
    logic [RADDR_W-1:0] rd;
    logic memtoreg;
    logic regwrite;
  } entry_t;
  memwb_state_e state, state_nx;
  entry_t in_entry, out_d, out_q, skid_q;
  logic accept, rel, out_load, skid_load;
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign accept = in_valid & in_ready;
  assign rel = out_valid & out_ready;
  assign in_entry = '{result: result_in, read_data: read_data_in, rd: rd_in,
                      memtoreg: memtoreg_in, regwrite: regwrite_in & (rd_in != '0)};
  always_ff @(posedge clk)
    if (!reset) state <= EMPTY;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    out_load = 1'b0;
    skid_load = 1'b0;
    out_d = in_entry;
    if (!flush) begin
      state_nx = state == EMPTY ? (accept ? ONE : EMPTY) :
                 state == ONE   ? (accept && !rel ? FULL : (!accept && rel ? EMPTY : ONE)) :
                                  (rel ? ONE : FULL);
      out_load = state == FULL ? rel : accept && (state == EMPTY || rel);
      skid_load = state == ONE && accept && !rel;
      out_d = state == FULL ? skid_q : in_entry;
    end else state_nx = EMPTY;
  end
  memwb_slot #(.entry_t(entry_t)) u_out (
    .clk(clk), .reset(reset), .load(out_load), .d(out_d), .q(out_q)
  );
  memwb_slot #(.entry_t(entry_t)) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .d(in_entry), .q(skid_q)
  );
  assign result_out = out_q.result;
  assign read_data_out = out_q.read_data;
  assign rd_out = out_q.rd;
  assign memtoreg_out = out_q.memtoreg;
  assign regwrite_out = out_q.regwrite & out_valid;
  assign wb_data = out_q.memtoreg ? out_q.read_data : out_q.result;
`ifdef MEMWB_FWD_EN
  assign fwd_en = out_valid & regwrite_out;
  assign fwd_rd = rd_out;
  assign fwd_data = wb_data;
`endif
endmodule

// File: tb/tb_memwb_stage.sv
// tb_memwb_stage: table, directed and randomized checks of memwb_stage against a queue model
module tb_memwb_stage;
  logic clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic memtoreg_in = 0, regwrite_in = 0;
  logic [63:0] result_in = 0, read_data_in = 0;
  logic [4:0] rd_in = 0;
  logic in_ready, out_valid, memtoreg_out, regwrite_out;
  logic [63:0] result_out, read_data_out, wb_data;
  logic [4:0] rd_out;
`ifdef MEMWB_FWD_EN
  logic fwd_en;
  logic [4:0] fwd_rd;
  logic [63:0] fwd_data;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  memwb_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .result_in(result_in), .read_data_in(read_data_in), .rd_in(rd_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .out_valid(out_valid),
    .out_ready(out_ready), .result_out(result_out), .read_data_out(read_data_out),
    .rd_out(rd_out), .memtoreg_out(memtoreg_out), .regwrite_out(regwrite_out),
    .wb_data(wb_data)
`ifdef MEMWB_FWD_EN
    , .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );
  typedef struct {
    logic [63:0] res;
    logic [63:0] rdat;
    logic [4:0] rd;
    bit m2r;
    bit rw;
  } ent_t;
  ent_t q[$];
  ent_t shown;
  typedef struct {
    bit iv;
    logic [63:0] res;
    bit ordy;
    bit fl;
    bit exp_ov;
    bit exp_ir;
    logic [63:0] exp_res;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_step();
    bit acc, rl;
    ent_t e;
    if (!reset) begin
      q.delete();
      shown = '{default: 0};
    end else if (flush) q.delete();
    else begin
      acc = in_valid && q.size() < 2;
      rl = q.size() > 0 && out_ready;
      e = '{res: result_in, rdat: read_data_in, rd: rd_in, m2r: memtoreg_in,
            rw: regwrite_in && rd_in != 0};
      if (rl) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (q.size() > 0) shown = q[0];
    end
  endtask
  task automatic check_model();
    bit ov;
    ov = q.size() > 0;
    chk("out_valid", out_valid, ov);
    chk("in_ready", in_ready, q.size() < 2);
    chk("result_out", result_out, shown.res);
    chk("read_data_out", read_data_out, shown.rdat);
    chk("rd_out", rd_out, shown.rd);
    chk("memtoreg_out", memtoreg_out, shown.m2r);
    chk("regwrite_out", regwrite_out, shown.rw && ov);
    chk("wb_data", wb_data, shown.m2r ? shown.rdat : shown.res);
`ifdef MEMWB_FWD_EN
    chk("fwd_en", fwd_en, shown.rw && ov);
    chk("fwd_rd", fwd_rd, shown.rd);
    chk("fwd_data", fwd_data, shown.m2r ? shown.rdat : shown.res);
`endif
  endtask
  task automatic tick(input bit iv, input logic [63:0] res, input logic [63:0] rdat,
                      input logic [4:0] rd, input bit m2r, input bit rw,
                      input bit ordy, input bit fl, input bit rst_n);
    in_valid = iv; result_in = res; read_data_in = rdat; rd_in = rd;
    memtoreg_in = m2r; regwrite_in = rw; out_ready = ordy; flush = fl; reset = rst_n;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask
  initial begin
    shown = '{default: 0};
    tbl[0]  = '{1, 64'hA, 1, 0, 1, 1, 64'hA};
    tbl[1]  = '{1, 64'hB, 1, 0, 1, 1, 64'hB};
    tbl[2]  = '{1, 64'hC, 1, 0, 1, 1, 64'hC};
    tbl[3]  = '{0, 64'h0, 1, 0, 0, 1, 64'hC};
    tbl[4]  = '{1, 64'hA, 0, 0, 1, 1, 64'hA};
    tbl[5]  = '{1, 64'hB, 0, 0, 1, 0, 64'hA};
    tbl[6]  = '{1, 64'hD, 0, 0, 1, 0, 64'hA};
    tbl[7]  = '{0, 64'h0, 1, 0, 1, 1, 64'hB};
    tbl[8]  = '{0, 64'h0, 1, 0, 0, 1, 64'hB};
    tbl[9]  = '{1, 64'hE, 0, 0, 1, 1, 64'hE};
    tbl[10] = '{1, 64'hF, 0, 0, 1, 0, 64'hE};
    tbl[11] = '{1, 64'h77, 1, 1, 0, 1, 64'hE};
    tbl[12] = '{0, 64'h0, 1, 0, 0, 1, 64'hE};
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(1, 64'h1234, 64'h55, 5'd3, 1, 1, 1, 0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result_out, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_regwrite", regwrite_out, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].iv, tbl[i].res, 0, 5'd3, 0, 1, tbl[i].ordy, tbl[i].fl, 1);
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].exp_ov);
      chk($sformatf("tbl%0d_ir", i), in_ready, tbl[i].exp_ir);
      chk($sformatf("tbl%0d_res", i), result_out, tbl[i].exp_res);
      if (tbl[i].exp_ov) chk($sformatf("tbl%0d_rw", i), regwrite_out, 1);
    end
    tick(1, 64'h99, 0, 5'd0, 0, 1, 0, 0, 1);
    chk("x0_regwrite", regwrite_out, 0);
    chk("x0_out_valid", out_valid, 1);
`ifdef MEMWB_FWD_EN
    chk("x0_fwd_en", fwd_en, 0);
`endif
    tick(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick(1, 64'hBEEF, 64'hDEAD, 5'd7, 1, 1, 0, 0, 1);
    chk("m2r_wb_data", wb_data, 64'hDEAD);
    chk("m2r_regwrite", regwrite_out, 1);
`ifdef MEMWB_FWD_EN
    chk("m2r_fwd_en", fwd_en, 1);
    chk("m2r_fwd_rd", fwd_rd, 7);
    chk("m2r_fwd_data", fwd_data, 64'hDEAD);
`endif
    tick(0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
           5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 59) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
